// File: rtl/chan_fir_coef_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chan_fir_coef_pkg
//  Brief    : Shared types and field positions for the FIR coefficient-pair
//             loaders of the 550-channel channelizer.
//  Revision : 1.0  initial release
// ============================================================================
package chan_fir_coef_pkg;

    localparam int COEF_W  = 16;
    localparam int REG_W   = 32;

    localparam int B16_MSB = 31;
    localparam int B16_LSB = 16;
    localparam int B17_MSB = 15;
    localparam int B17_LSB = 0;

    // Loader sequencing: wait for a change, qualify it, then wait for a frame sync.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ARMED   = 2'd2
    } load_state_t;

    typedef struct packed {
        logic [COEF_W-1:0] b16;
        logic [COEF_W-1:0] b17;
    } coef_pair_t;

    // Split a software register word into its two coefficient fields, unmodified.
    function automatic coef_pair_t unpack_pair(input logic [REG_W-1:0] word);
        coef_pair_t pair;
        pair.b16 = word[B16_MSB:B16_LSB];
        pair.b17 = word[B17_MSB:B17_LSB];
        return pair;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_reg_qualifier.sv
`default_nettype none
// ============================================================================
//  Module   : fir_reg_qualifier
//  Brief    : Detects a new register word and flags it once it has held
//             steady for STABLE_CYCLES consecutive edges.
//  Revision : 1.0  initial release
// ============================================================================
module fir_reg_qualifier
    import chan_fir_coef_pkg::*;
#(
    parameter int WORD_W        = REG_W,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word_in,
    output logic              change_det,
    output logic              qualified_valid,
    output logic [WORD_W-1:0] qualified_word
);

    localparam logic [8:0] c_STABLE = 9'(STABLE_CYCLES);

    logic [WORD_W-1:0] r_last_seen;
    logic [7:0]        r_stable_cnt;
    logic              r_counting;
    logic [8:0]        w_cnt_inc;

    assign change_det      = (word_in != r_last_seen);
    assign w_cnt_inc       = {1'b0, r_stable_cnt} + 9'd1;
    // Fires on the edge whose increment reaches the threshold, so the
    // consumer registers the word exactly STABLE_CYCLES edges after the change.
    assign qualified_valid = r_counting && !change_det && (w_cnt_inc == c_STABLE);
    assign qualified_word  = r_last_seen;

    // Track the last word seen and count consecutive stable edges after a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_seen  <= '0;
            r_stable_cnt <= '0;
            r_counting   <= 1'b0;
        end else if (change_det) begin
            r_last_seen  <= word_in;
            r_stable_cnt <= '0;
            r_counting   <= 1'b1;
        end else if (r_counting) begin
            r_stable_cnt <= w_cnt_inc[7:0];
            if (qualified_valid) begin
                r_counting <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coeff_pair_loader
//  Brief    : Qualifies the b16/b17 coefficient register word, holds it in a
//             shadow buffer and applies it to the FIR taps on frame sync.
//  Revision : 1.0  initial release
// ============================================================================
module fir_coeff_pair_loader
    import chan_fir_coef_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       reg_data,
    input  logic              frame_sync,
    output logic [15:0]       coef_b16,
    output logic [15:0]       coef_b17,
    output logic              coef_valid,
    output logic              update_pending,
    output logic              apply_pulse,
    output logic              sync_out,
    output logic [CNT_W-1:0]  update_count
);

    load_state_t       r_state;
    load_state_t       w_next_state;
    logic              w_do_arm;
    logic              w_do_apply;

    logic              w_change;
    logic              w_qual_valid;
    logic [REG_W-1:0]  w_qual_word;

    coef_pair_t        r_shadow;
    coef_pair_t        r_active;
    logic              r_coef_valid;
    logic              r_pending;
    logic              r_apply;
    logic              r_sync;
    logic [CNT_W-1:0]  r_count;

    fir_reg_qualifier #(
        .WORD_W        (REG_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_qualifier (
        .clk             (user_clk),
        .rst_n           (user_rst_n),
        .word_in         (reg_data),
        .change_det      (w_change),
        .qualified_valid (w_qual_valid),
        .qualified_word  (w_qual_word)
    );

    // State register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a register change always wins over a frame sync.
    always_comb begin
        w_next_state = r_state;
        w_do_arm     = 1'b0;
        w_do_apply   = 1'b0;
        if (w_change) begin
            w_next_state = QUALIFY;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state = IDLE;
                end
                QUALIFY: begin
                    if (w_qual_valid) begin
                        w_next_state = ARMED;
                        w_do_arm     = 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_sync) begin
                        w_next_state = IDLE;
                        w_do_apply   = 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Shadow capture, frame-aligned apply, and the registered strobes.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_coef_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_apply      <= 1'b0;
            r_sync       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_apply <= w_do_apply;
            r_sync  <= frame_sync;
            if (w_change) begin
                r_pending <= 1'b0;
            end else if (w_do_arm) begin
                r_shadow  <= unpack_pair(w_qual_word);
                r_pending <= 1'b1;
            end else if (w_do_apply) begin
                r_active     <= r_shadow;
                r_coef_valid <= 1'b1;
                r_pending    <= 1'b0;
                r_count      <= r_count + 1'b1;
            end
        end
    end

    assign coef_b16       = r_active.b16;
    assign coef_b17       = r_active.b17;
    assign coef_valid     = r_coef_valid;
    assign update_pending = r_pending;
    assign apply_pulse    = r_apply;
    assign sync_out       = r_sync;
    assign update_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_coeff_pair_loader
//  Brief    : Scoreboard bench for fir_coeff_pair_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_coeff_pair_loader;

    logic        user_clk;
    logic        user_rst_n;
    logic [31:0] reg_data;
    logic        frame_sync;
    logic [15:0] coef_b16;
    logic [15:0] coef_b17;
    logic        coef_valid;
    logic        update_pending;
    logic        apply_pulse;
    logic        sync_out;
    logic [7:0]  update_count;

    typedef struct packed {
        logic [15:0] b16;
        logic [15:0] b17;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         total;
    int         bad;
    logic [7:0] exp_count;

    fir_coeff_pair_loader #(
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .user_clk       (user_clk),
        .user_rst_n     (user_rst_n),
        .reg_data       (reg_data),
        .frame_sync     (frame_sync),
        .coef_b16       (coef_b16),
        .coef_b17       (coef_b17),
        .coef_valid     (coef_valid),
        .update_pending (update_pending),
        .apply_pulse    (apply_pulse),
        .sync_out       (sync_out),
        .update_count   (update_count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    // Expect one apply with the given pair on the next frame sync.
    task automatic expect_apply(input logic [31:0] word);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.b16 = word[31:16];
        e.b17 = word[15:0];
        e.cnt = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge user_clk);
            if (user_rst_n && apply_pulse) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_apply", {16'd0, coef_b16}, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("apply_b16",   {16'd0, coef_b16},    {16'd0, e.b16});
                    chk("apply_b17",   {16'd0, coef_b17},    {16'd0, e.b17});
                    chk("apply_count", {24'd0, update_count}, {24'd0, e.cnt});
                    chk("apply_sync",  {31'd0, sync_out},     32'd1);
                    chk("apply_valid", {31'd0, coef_valid},   32'd1);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_b16"},     {16'd0, coef_b16},       32'd0);
        chk({nm, "_b17"},     {16'd0, coef_b17},       32'd0);
        chk({nm, "_valid"},   {31'd0, coef_valid},     32'd0);
        chk({nm, "_pending"}, {31'd0, update_pending}, 32'd0);
        chk({nm, "_apply"},   {31'd0, apply_pulse},    32'd0);
        chk({nm, "_sync"},    {31'd0, sync_out},       32'd0);
        chk({nm, "_count"},   {24'd0, update_count},   32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_count  = 8'd0;
        user_rst_n = 1'b0;
        reg_data   = 32'd0;
        frame_sync = 1'b0;
        fork
            monitor();
        join_none

        #13 user_rst_n = 1'b1;
        tick(1);
        chk_all_zero("reset");

        // Zero register after reset never updates, even across many frames.
        for (int i = 0; i < 20; i++) begin
            frame_sync = 1'b1;
            tick(1);
            frame_sync = 1'b0;
            tick(1);
        end
        chk_all_zero("zero_word");

        // Single write: pending exactly 4 edges after the change edge.
        reg_data = 32'h7FFF_8001;
        tick(1);
        chk("pend_k0", {31'd0, update_pending}, 32'd0);
        tick(3);
        chk("pend_k3", {31'd0, update_pending}, 32'd0);
        tick(1);
        chk("pend_k4", {31'd0, update_pending}, 32'd1);
        chk("pend_not_applied", {31'd0, coef_valid}, 32'd0);
        tick(5);
        frame_sync = 1'b1;
        expect_apply(32'h7FFF_8001);
        tick(1);
        frame_sync = 1'b0;
        chk("post_apply_pending", {31'd0, update_pending}, 32'd0);
        tick(1);
        chk("pulse_one_cycle", {31'd0, apply_pulse}, 32'd0);

        // Unstable register: toggles every 2 cycles never qualify.
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                reg_data = (i % 4 == 0) ? 32'h0001_0002 : 32'h0003_0004;
            end
            frame_sync = (i % 8 == 7);
            tick(1);
            chk("toggle_pending", {31'd0, update_pending}, 32'd0);
        end
        frame_sync = 1'b0;
        chk("toggle_b16",   {16'd0, coef_b16},     32'h0000_7FFF);
        chk("toggle_b17",   {16'd0, coef_b17},     32'h0000_8001);
        chk("toggle_count", {24'd0, update_count}, 32'd1);

        // Change coinciding with frame sync in ARMED: change wins.
        reg_data = 32'h1111_2222;
        tick(6);
        chk("armed_pending", {31'd0, update_pending}, 32'd1);
        reg_data   = 32'h3333_4444;
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        chk("race_no_apply", {31'd0, apply_pulse},    32'd0);
        chk("race_pending",  {31'd0, update_pending}, 32'd0);
        chk("race_b16_held", {16'd0, coef_b16},       32'h0000_7FFF);
        tick(3);
        chk("race_pend_k3", {31'd0, update_pending}, 32'd0);
        tick(1);
        chk("race_pend_k4", {31'd0, update_pending}, 32'd1);
        frame_sync = 1'b1;
        expect_apply(32'h3333_4444);
        tick(1);
        frame_sync = 1'b0;

        // 256 qualified updates: counter wraps back to its start value.
        for (int i = 0; i < 256; i++) begin
            reg_data = 32'h0100_0000 + (32'(i) * 32'h0001_0001);
            tick(5);
            frame_sync = 1'b1;
            expect_apply(reg_data);
            tick(1);
            frame_sync = 1'b0;
        end
        tick(2);
        chk("wrap_count", {24'd0, update_count}, 32'd2);
        chk("wrap_valid", {31'd0, coef_valid},   32'd1);

        // Asynchronous reset in the middle of qualification.
        reg_data = 32'h5555_6666;
        tick(2);
        #3 user_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        reg_data = 32'd0;
        tick(2);
        #2 user_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame_sync = 1'b1;
            tick(1);
            frame_sync = 1'b0;
            tick(1);
        end
        chk_all_zero("after_rst");

        tick(3);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
